// File: rtl/io_handshake_sequencer_if.sv
// Board/core signal bundle for io_handshake_sequencer; the master modport is the
// core plus board side, the slave modport is the sequencer itself.
interface io_handshake_sequencer_if #(
    parameter int SWITCH_WIDTH = 16
);
    logic                    is_input;
    logic                    is_output;
    logic [31:0]             out_data;
    logic [SWITCH_WIDTH-1:0] switches;
    logic                    confirm_btn;
    logic                    core_enable;
    logic [31:0]             in_data;
    logic                    in_valid;
    logic [31:0]             display_data;
    logic                    display_valid;
    logic                    busy;
    // Observation points: FSM state encoding and the debounced button level.
    logic [2:0]              state_dbg;
    logic                    btn_db_dbg;

    // Handshake: core_enable is a stall qualifier, not valid/ready. The core
    // commits only in a cycle where core_enable=1; in_valid is a single-cycle
    // strobe that qualifies in_data and only ever coincides with core_enable=1.
    modport master (
        output is_input, is_output, out_data, switches, confirm_btn,
        input  core_enable, in_data, in_valid, display_data, display_valid, busy,
        input  state_dbg, btn_db_dbg
    );

    modport slave (
        input  is_input, is_output, out_data, switches, confirm_btn,
        output core_enable, in_data, in_valid, display_data, display_valid, busy,
        output state_dbg, btn_db_dbg
    );
endinterface

// File: rtl/io_handshake_sequencer.sv
// Stalls the core on OUTSS/INSW until the operator completes a press/release on
// the confirm button. Define IO_DEBOUNCE_EN to add the button debouncer.
module io_handshake_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SWITCH_WIDTH    = 16
) (
    input logic                    clock,
    input logic                    reset,
    io_handshake_sequencer_if.slave io
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ARM          = 3'd1,
        WAIT_PRESS   = 3'd2,
        WAIT_RELEASE = 3'd3,
        DONE         = 3'd4
    } state_t;

    state_t      state, next_state;
    logic [1:0]  sync_q;
    logic        btn_sync;
    logic        btn_db;
    logic        op_is_output;
    logic        start;
    logic        capture;
    logic        core_enable;
    logic        in_valid;
    logic [31:0] in_data_q;
    logic [31:0] display_data_q;
    logic        display_valid_q;

    // The button is asynchronous to clock; two flops before anything looks at it.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], io.confirm_btn};
        end
    end
    assign btn_sync = sync_q[1];

`ifdef IO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_count;
    logic             db_level;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_count <= '0;
            db_level <= 1'b0;
        end else if (btn_sync != db_level) begin
            if (db_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_count <= '0;
                db_level <= btn_sync;
            end else begin
                db_count <= db_count + CNT_W'(1);
            end
        end else begin
            db_count <= '0;
        end
    end
    assign btn_db = db_level;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign btn_db = btn_sync;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        core_enable = 1'b0;
        in_valid    = 1'b0;
        start       = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                // Combinational so the I/O instruction is held off in its first cycle.
                core_enable = !(io.is_input | io.is_output);
                if (io.is_input | io.is_output) begin
                    start      = 1'b1;
                    next_state = btn_db ? ARM : WAIT_PRESS;
                end
            end
            ARM: begin
                if (!btn_db) next_state = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (btn_db) begin
                    capture    = 1'b1;
                    next_state = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!btn_db) next_state = DONE;
            end
            DONE: begin
                core_enable = 1'b1;
                in_valid    = !op_is_output;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output wins when both decode flags are set.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_is_output    <= 1'b0;
            in_data_q       <= 32'd0;
            display_data_q  <= 32'd0;
            display_valid_q <= 1'b0;
        end else begin
            if (start) op_is_output <= io.is_output;
            if (capture) begin
                if (op_is_output) begin
                    display_data_q  <= io.out_data;
                    display_valid_q <= 1'b1;
                end else begin
                    in_data_q <= 32'(io.switches);
                end
            end
        end
    end

    assign io.core_enable   = core_enable;
    assign io.in_valid      = in_valid;
    assign io.in_data       = in_data_q;
    assign io.display_data  = display_data_q;
    assign io.display_valid = display_valid_q;
    assign io.busy          = (state != IDLE);
    assign io.state_dbg     = state;
    assign io.btn_db_dbg    = btn_db;

endmodule

// File: tb/tb_io_handshake_sequencer.sv
// Directed bench for io_handshake_sequencer: output, input, held button,
// priority, back-to-back INSW, reset mid-handshake and (if enabled) debounce.
module tb_io_handshake_sequencer;

    localparam int DEBOUNCE_CYCLES = 16;
    localparam int SWITCH_WIDTH    = 16;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 2 + DEBOUNCE_CYCLES;
`else
    localparam int LAT = 2;
`endif

    localparam logic [31:0] S_IDLE = 32'd0, S_ARM = 32'd1, S_WP = 32'd2,
                            S_WR = 32'd3, S_DONE = 32'd4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    bit   stall_chk = 1'b0;
    bit   quiet_chk = 1'b0;

    always #5 clock = ~clock;

    io_handshake_sequencer_if #(.SWITCH_WIDTH(SWITCH_WIDTH)) io ();

    io_handshake_sequencer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SWITCH_WIDTH   (SWITCH_WIDTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io   (io)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling 2ns after each rising edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #2;
            if (stall_chk) chk("stall_core_enable", 32'(io.core_enable), 32'd0);
            if (quiet_chk) begin
                chk("quiet_in_valid", 32'(io.in_valid), 32'd0);
                chk("quiet_state", 32'(io.state_dbg), S_IDLE);
            end
        end
    endtask

    initial begin
        io.is_input    = 1'b0;
        io.is_output   = 1'b0;
        io.out_data    = 32'd0;
        io.switches    = '0;
        io.confirm_btn = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);

        // Reset state
        chk("rst_state", 32'(io.state_dbg), S_IDLE);
        chk("rst_busy", 32'(io.busy), 32'd0);
        chk("rst_in_data", io.in_data, 32'd0);
        chk("rst_in_valid", 32'(io.in_valid), 32'd0);
        chk("rst_disp_data", io.display_data, 32'd0);
        chk("rst_disp_valid", 32'(io.display_valid), 32'd0);
        chk("rst_core_enable", 32'(io.core_enable), 32'd1);

        // OUTSS 0xA5
        io.out_data  = 32'h0000_00A5;
        io.is_output = 1'b1;
        #1;
        chk("out_idle_stall", 32'(io.core_enable), 32'd0);
        cyc(1);
        chk("out_state_wp", 32'(io.state_dbg), S_WP);
        stall_chk = 1'b1;
        io.confirm_btn = 1'b1;
        cyc(LAT);
        chk("out_btn_db_up", 32'(io.btn_db_dbg), 32'd1);
        chk("out_disp_not_yet", io.display_data, 32'd0);
        cyc(1);
        chk("out_disp_data", io.display_data, 32'h0000_00A5);
        chk("out_disp_valid", 32'(io.display_valid), 32'd1);
        chk("out_state_wr", 32'(io.state_dbg), S_WR);
        io.confirm_btn = 1'b0;
        cyc(LAT);
        chk("out_still_wr", 32'(io.state_dbg), S_WR);
        stall_chk = 1'b0;
        cyc(1);
        chk("out_state_done", 32'(io.state_dbg), S_DONE);
        chk("out_done_enable", 32'(io.core_enable), 32'd1);
        chk("out_done_no_valid", 32'(io.in_valid), 32'd0);
        io.is_output = 1'b0;
        cyc(1);
        chk("out_back_idle", 32'(io.state_dbg), S_IDLE);
        chk("out_busy_clear", 32'(io.busy), 32'd0);

        // INSW 0xBEEF, switches change before release
        io.switches = 16'hBEEF;
        io.is_input = 1'b1;
        cyc(1);
        stall_chk = 1'b1;
        io.confirm_btn = 1'b1;
        cyc(LAT + 1);
        chk("in_state_wr", 32'(io.state_dbg), S_WR);
        chk("in_captured", io.in_data, 32'h0000_BEEF);
        io.switches = 16'h1234;
        io.confirm_btn = 1'b0;
        cyc(LAT);
        stall_chk = 1'b0;
        cyc(1);
        chk("in_state_done", 32'(io.state_dbg), S_DONE);
        chk("in_valid_pulse", 32'(io.in_valid), 32'd1);
        chk("in_valid_enable", 32'(io.core_enable), 32'd1);
        chk("in_data_held", io.in_data, 32'h0000_BEEF);
        io.is_input = 1'b0;
        cyc(1);
        chk("in_valid_drop", 32'(io.in_valid), 32'd0);

        // Button held before OUTSS
        io.confirm_btn = 1'b1;
        cyc(LAT + 1);
        io.out_data  = 32'h0000_0055;
        io.is_output = 1'b1;
        cyc(1);
        chk("held_state_arm", 32'(io.state_dbg), S_ARM);
        stall_chk = 1'b1;
        cyc(3);
        chk("held_still_arm", 32'(io.state_dbg), S_ARM);
        chk("held_no_capture", io.display_data, 32'h0000_00A5);
        io.confirm_btn = 1'b0;
        cyc(LAT);
        chk("held_arm_until_low", 32'(io.state_dbg), S_ARM);
        cyc(1);
        chk("held_state_wp", 32'(io.state_dbg), S_WP);
        io.confirm_btn = 1'b1;
        cyc(LAT + 1);
        chk("held_capture", io.display_data, 32'h0000_0055);
        io.confirm_btn = 1'b0;
        cyc(LAT);
        stall_chk = 1'b0;
        cyc(1);
        chk("held_state_done", 32'(io.state_dbg), S_DONE);
        io.is_output = 1'b0;
        cyc(1);

`ifdef IO_DEBOUNCE_EN
        // 10-cycle glitch is filtered, 20-cycle press lands at exactly LAT
        quiet_chk = 1'b1;
        io.confirm_btn = 1'b1;
        cyc(10);
        io.confirm_btn = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            chk("glitch_btn_db", 32'(io.btn_db_dbg), 32'd0);
        end
        io.confirm_btn = 1'b1;
        cyc(LAT - 1);
        chk("db_not_early", 32'(io.btn_db_dbg), 32'd0);
        cyc(1);
        chk("db_rise_18", 32'(io.btn_db_dbg), 32'd1);
        cyc(2);
        io.confirm_btn = 1'b0;
        cyc(LAT + 1);
        chk("db_fall", 32'(io.btn_db_dbg), 32'd0);
        quiet_chk = 1'b0;
`endif

        // Both flags: output wins
        io.out_data  = 32'h0000_0077;
        io.switches  = 16'h0F0F;
        io.is_input  = 1'b1;
        io.is_output = 1'b1;
        cyc(1);
        io.confirm_btn = 1'b1;
        cyc(LAT + 1);
        chk("prio_disp", io.display_data, 32'h0000_0077);
        chk("prio_in_untouched", io.in_data, 32'h0000_BEEF);
        io.confirm_btn = 1'b0;
        cyc(LAT + 1);
        chk("prio_state_done", 32'(io.state_dbg), S_DONE);
        chk("prio_no_in_valid", 32'(io.in_valid), 32'd0);
        io.is_input  = 1'b0;
        io.is_output = 1'b0;
        cyc(1);

        // Two consecutive INSW with is_input held high
        io.is_input = 1'b1;
        io.switches = 16'h1111;
        cyc(1);
        io.confirm_btn = 1'b1;
        cyc(LAT + 1);
        io.confirm_btn = 1'b0;
        cyc(LAT + 1);
        chk("b2b_first_valid", 32'(io.in_valid), 32'd1);
        chk("b2b_first_data", io.in_data, 32'h0000_1111);
        io.switches = 16'h2222;
        cyc(1);
        chk("b2b_idle_between", 32'(io.state_dbg), S_IDLE);
        chk("b2b_idle_stall", 32'(io.core_enable), 32'd0);
        chk("b2b_idle_no_valid", 32'(io.in_valid), 32'd0);
        cyc(1);
        chk("b2b_second_wp", 32'(io.state_dbg), S_WP);
        io.confirm_btn = 1'b1;
        cyc(LAT + 1);
        io.confirm_btn = 1'b0;
        cyc(LAT + 1);
        chk("b2b_second_valid", 32'(io.in_valid), 32'd1);
        chk("b2b_second_data", io.in_data, 32'h0000_2222);
        io.is_input = 1'b0;
        cyc(1);

        // Reset while in WAIT_RELEASE
        io.out_data  = 32'h0000_0099;
        io.is_output = 1'b1;
        cyc(1);
        io.confirm_btn = 1'b1;
        cyc(LAT + 1);
        chk("rwr_state_wr", 32'(io.state_dbg), S_WR);
        chk("rwr_disp_valid", 32'(io.display_valid), 32'd1);
        reset = 1'b1;
        io.is_output = 1'b0;
        io.confirm_btn = 1'b0;
        cyc(1);
        chk("rwr_state_idle", 32'(io.state_dbg), S_IDLE);
        chk("rwr_busy", 32'(io.busy), 32'd0);
        chk("rwr_disp_valid_clr", 32'(io.display_valid), 32'd0);
        chk("rwr_disp_data_clr", io.display_data, 32'd0);
        chk("rwr_in_data_clr", io.in_data, 32'd0);
        reset = 1'b0;
        quiet_chk = 1'b1;
        cyc(LAT + 3);
        quiet_chk = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_handshake_sequencer.md
# io_handshake_sequencer

Multi-cycle sequencer for the core's I/O instructions (OUTSS, INSW). It sits between the control unit's `is_input`/`is_output` decode flags and the board's confirm button, switches and display. It stalls the core by dropping `core_enable` until the operator completes a debounced press/release handshake, then lets the instruction commit for exactly one cycle.

## Interface
**Parameters**
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed before the debounced button level changes (≥1).
- `SWITCH_WIDTH`, 16: width of the switch bank.

**Ports**
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `is_input` in 1: current instruction is INSW.
- `is_output` in 1: current instruction is OUTSS.
- `out_data` in 32: register value to display.
- `switches` in SWITCH_WIDTH: raw switch bank.
- `confirm_btn` in 1: raw button, active-high, asynchronous to `clock`.
- `core_enable` out 1: 1 = core may commit/advance this cycle.
- `in_data` out 32: switches captured at press, zero-extended.
- `in_valid` out 1: one-cycle pulse qualifying `in_data` for register write-back.
- `display_data` out 32: last value output.
- `display_valid` out 1: at least one OUTSS has completed since reset.
- `busy` out 1: FSM not in IDLE.

## Operation
- Button path: 2-flop synchronizer → debouncer → level `btn_db`. Debouncer counter increments while sync ≠ `btn_db` and clears when they are equal. `btn_db` flips when the count reaches DEBOUNCE_CYCLES. Reset: sync flops 0, `btn_db` 0, count 0.
- FSM states: IDLE, ARM, WAIT_PRESS, WAIT_RELEASE, DONE.
- IDLE: `core_enable = !(is_input | is_output)` (combinational, so the I/O instruction never commits early). On a request, latch `op_is_output = is_output`. Both flags high: output takes priority. Go to ARM if `btn_db`=1, else WAIT_PRESS.
- ARM: wait for `btn_db`=0, then WAIT_PRESS. A button held at instruction start is never taken as a confirmation.
- WAIT_PRESS: on `btn_db`=1:
  - Output: `display_data <= out_data`, `display_valid <= 1`.
  - Input: `in_data <= {zeros, switches}`.
  - Then go to WAIT_RELEASE.
- WAIT_RELEASE: on `btn_db`=0, go to DONE.
- DONE: `core_enable`=1; `in_valid`=1 if input; next state IDLE unconditionally. Flags seen in the following IDLE cycle belong to the next instruction, so back-to-back INSW runs two full handshakes.
- `core_enable`=0 in ARM, WAIT_PRESS, WAIT_RELEASE. `busy`=1 outside IDLE.
- Switch changes after the press edge do not affect `in_data`.
- `is_input`/`is_output` are ignored outside IDLE: the core is stalled, so its decode is stable.

## Timing
- Reset values: state IDLE, `in_data` 0, `in_valid` 0, `display_data` 0, `display_valid` 0, `busy` 0. `core_enable` follows the IDLE equation.
- Raw button edge to `btn_db` change: 2 + DEBOUNCE_CYCLES cycles, if the button is stable throughout.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles is ignored.
- Minimum stall per I/O instruction, clean press at request cycle: 1 (IDLE→WAIT_PRESS) + press latency + release latency + 1 (DONE).
- `display_data` updates the cycle after `btn_db` rises. It stays held until the next OUTSS or reset.
- Reset mid-handshake: return to IDLE next edge, outputs cleared, no `in_valid` pulse; the core re-executes the instruction.

## Configuration
- `IO_DEBOUNCE_EN` defined: debouncer as above.
- `IO_DEBOUNCE_EN` undefined:
  - `btn_db` is the synchronizer output directly (latency 2).
  - No counter logic; `DEBOUNCE_CYCLES` unused.
  - All FSM behaviour is otherwise identical.

## Test plan
- Output: `out_data`=0x0000_00A5, `is_output`=1, press 3 cycles then release (debounce off) → `core_enable` 0 throughout; `display_data`=0xA5 the cycle after `btn_db` rises; single `core_enable`=1 cycle in DONE; `display_valid`=1.
- Input: `switches`=0xBEEF, `is_input`=1, press; switches change to 0x1234 before release → `in_data`=0x0000_BEEF with one-cycle `in_valid` coincident with `core_enable`=1.
- Held button: `confirm_btn`=1 before `is_output` → FSM sits in ARM, no capture; release then press → normal completion.
- Debounce (DEBOUNCE_CYCLES=16): 10-cycle pulse → no state change. 20-cycle press → `btn_db` rises exactly 18 cycles after the raw edge.
- Priority/back-to-back: `is_input`=`is_output`=1 → output path taken. Two consecutive INSW → two separate handshakes, two `in_valid` pulses.
- Reset in WAIT_RELEASE → next cycle IDLE, `display_valid`=0, `in_valid` never pulses, `busy`=0.
